// File: rtl/ic_mux_scan.sv
// ic_mux_scan: registered N-channel mux with active-low enable, manual select and auto-scan.
// Define IC_MUX_SCAN_PARITY_EN to add the registered even-parity output P.
module ic_mux_scan #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      E,
    input  logic                      MODE,
    input  logic [SEL_W-1:0]          S,
    input  logic                      LD,
    input  logic [CHANNELS*WIDTH-1:0] D,
    output logic [WIDTH-1:0]          Y,
    output logic [SEL_W-1:0]          CH,
    output logic                      WRAP,
    output logic                      ERR
`ifdef IC_MUX_SCAN_PARITY_EN
    ,
    output logic                      P
`endif
);
    // One extra bit keeps the last-channel compare free of aliasing for power-of-two counts
    localparam logic [SEL_W:0] LAST = (SEL_W+1)'(CHANNELS - 1);
    logic [SEL_W-1:0] cnt;
    logic [SEL_W-1:0] sel;
    logic [SEL_W:0]   selx;
    logic [WIDTH-1:0] y_nxt;
    assign sel  = (MODE && !LD) ? cnt : S;
    assign selx = {1'b0, sel};
    always_comb begin
        y_nxt = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (selx == (SEL_W+1)'(k)) y_nxt = D[k*WIDTH +: WIDTH];
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Y    <= '0;
            CH   <= '0;
            WRAP <= 1'b0;
            ERR  <= 1'b0;
            cnt  <= '0;
`ifdef IC_MUX_SCAN_PARITY_EN
            P    <= 1'b0;
`endif
        end else if (E) begin
            Y    <= '0;
            WRAP <= 1'b0;
            ERR  <= 1'b0;
`ifdef IC_MUX_SCAN_PARITY_EN
            P    <= 1'b0;
`endif
        end else begin
            Y    <= y_nxt;
            CH   <= sel;
            ERR  <= selx > LAST;
            WRAP <= MODE && (selx == LAST);
            if (MODE) cnt <= (selx >= LAST) ? '0 : sel + 1'b1;
`ifdef IC_MUX_SCAN_PARITY_EN
            P    <= ^y_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_ic_mux_scan.sv
// tb_ic_mux_scan: directed checks of ic_mux_scan with 4-channel and 3-channel instances.
module tb_ic_mux_scan;
    logic        clk, rst, e, mode, ld;
    logic [1:0]  s;
    logic [15:0] d;
    logic [11:0] d3;
    logic [3:0]  y, y3;
    logic [1:0]  ch, ch3;
    logic        wrap, err, wrap3, err3;
`ifdef IC_MUX_SCAN_PARITY_EN
    logic        p, p3;
`endif
    int checks = 0;
    int errors = 0;

    ic_mux_scan #(.WIDTH(4), .CHANNELS(4)) dut (
        .CLK(clk), .RST(rst), .E(e), .MODE(mode), .S(s), .LD(ld), .D(d),
        .Y(y), .CH(ch), .WRAP(wrap), .ERR(err)
`ifdef IC_MUX_SCAN_PARITY_EN
        , .P(p)
`endif
    );

    ic_mux_scan #(.WIDTH(4), .CHANNELS(3)) dut3 (
        .CLK(clk), .RST(rst), .E(e), .MODE(mode), .S(s), .LD(ld), .D(d3),
        .Y(y3), .CH(ch3), .WRAP(wrap3), .ERR(err3)
`ifdef IC_MUX_SCAN_PARITY_EN
        , .P(p3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; e = 1'b0; mode = 1'b1; ld = 1'b0; s = 2'd0;
        d = 16'hDCBA; d3 = 12'hCBA;
        #12 rst = 1'b0;
        chk("rst_y", y, 0);
        chk("rst_ch", ch, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_err", err, 0);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("scan_y", y, 4'hA + i % 4);
            chk("scan_ch", ch, i % 4);
            chk("scan_wrap", wrap, (i % 4) == 3);
            chk("scan_err", err, 0);
        end
        ld = 1'b1; s = 2'd1;
        tick;
        chk("ld_y", y, 4'hB);
        chk("ld_ch", ch, 1);
        chk("ld_wrap", wrap, 0);
        ld = 1'b0;
        tick; chk("ld1_y", y, 4'hC); chk("ld1_ch", ch, 2);
        tick; chk("ld2_y", y, 4'hD); chk("ld2_ch", ch, 3); chk("ld2_wrap", wrap, 1);
        tick; chk("ld3_y", y, 4'hA); chk("ld3_ch", ch, 0); chk("ld3_wrap", wrap, 0);
        tick; chk("pre_frz_ch", ch, 1);
        e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("frz_y", y, 0);
            chk("frz_ch", ch, 1);
            chk("frz_wrap", wrap, 0);
        end
        e = 1'b0;
        tick; chk("unfrz_y", y, 4'hC); chk("unfrz_ch", ch, 2);
        #3 rst = 1'b1;
        #1;
        chk("arst_y", y, 0);
        chk("arst_ch", ch, 0);
        chk("arst_wrap", wrap, 0);
        chk("arst_err", err, 0);
        #2 rst = 1'b0;
        tick; chk("post_rst_y", y, 4'hA); chk("post_rst_ch", ch, 0);
        mode = 1'b0; s = 2'd2;
        tick; chk("man_y", y, 4'hC); chk("man_ch", ch, 2);
        s = 2'd3;
        tick; chk("man3_y", y, 4'hD); chk("man3_wrap", wrap, 0); chk("man3_err", err, 0);
        mode = 1'b1;
        tick; chk("resume_y", y, 4'hB); chk("resume_ch", ch, 1);
        mode = 1'b0; s = 2'd0;
        tick; chk("back_man_y", y, 4'hA); chk("back_man_ch", ch, 0);
        s = 2'd3;
        tick;
        chk("c3_oor_y", y3, 0); chk("c3_oor_err", err3, 1); chk("c3_oor_ch", ch3, 3);
        mode = 1'b1; ld = 1'b1;
        tick;
        chk("c3_ld_err", err3, 1); chk("c3_ld_ch", ch3, 3); chk("c3_ld_wrap", wrap3, 0);
        ld = 1'b0;
        tick; chk("c3_s0_ch", ch3, 0); chk("c3_s0_y", y3, 4'hA); chk("c3_s0_err", err3, 0);
        tick; chk("c3_s1_ch", ch3, 1); chk("c3_s1_y", y3, 4'hB); chk("c3_s1_wrap", wrap3, 0);
        tick; chk("c3_s2_ch", ch3, 2); chk("c3_s2_y", y3, 4'hC); chk("c3_s2_wrap", wrap3, 1);
        tick; chk("c3_s3_ch", ch3, 0); chk("c3_s3_wrap", wrap3, 0);
`ifdef IC_MUX_SCAN_PARITY_EN
        mode = 1'b0; d = 16'h0037; s = 2'd0;
        tick; chk("par7_y", y, 4'h7); chk("par7_p", p, 1);
        s = 2'd1;
        tick; chk("par3_y", y, 4'h3); chk("par3_p", p, 0);
        s = 2'd0; e = 1'b1;
        tick; chk("par_dis_p", p, 0);
        e = 1'b0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ic_mux_scan.md
# ic_mux_scan

Parametrised registered N-channel, WIDTH-bit multiplexer with an active-LOW enable, a manual select mode and an auto-scan sequencer mode. It is the clocked, generalised successor to the quad 2-input mux parts in the chip library. It is used wherever a bus must be time-shared across several sources, such as display multiplexing or round-robin sampling.

## Interface
- WIDTH, 4: bits per channel, ≥1.
- CHANNELS, 4: number of input channels, ≥2, power of two not required.
- SEL_W, $clog2(CHANNELS): select/counter width, derived; do not override.

- CLK  in  1: clock; all state updates on the rising edge.
- RST  in  1: reset; one clock, asynchronous, active-high.
- E  in  1: active-LOW enable.
- MODE  in  1: 0 = manual select, 1 = auto-scan.
- S  in  SEL_W: manual select, or scan start value when LD=1.
- LD  in  1: in scan mode, load S as the channel for this cycle.
- D  in  CHANNELS*WIDTH: flattened inputs; channel k occupies D[k*WIDTH +: WIDTH].
- Y  out  WIDTH: registered selected data.
- CH  out  SEL_W: registered index of the channel currently on Y.
- WRAP  out  1: registered one-cycle pulse when the channel on Y is the last channel, CHANNELS-1, in scan mode.
- ERR  out  1: registered; selected index ≥ CHANNELS.

## Operation
- Internal scan counter cnt (SEL_W bits).
- Per-edge select value sel:
  - MODE=0: sel = S.
  - MODE=1, LD=1: sel = S.
  - MODE=1, LD=0: sel = cnt.
- When E=0, each edge does the following:
  - Y <= (sel < CHANNELS) ? D[sel] : 0.
  - CH <= sel.
  - ERR <= (sel ≥ CHANNELS).
  - WRAP <= MODE & (sel == CHANNELS-1).
  - Scan mode only: cnt <= (sel ≥ CHANNELS-1) ? 0 : sel+1. An out-of-range load therefore restarts the scan at 0.
  - Manual mode only: cnt is held.
- When E=1, each edge does the following:
  - Y <= 0, WRAP <= 0, ERR <= 0.
  - CH and cnt are held, so the scan is frozen, not reset.
  - LD and S are ignored.
- Mode switch 0→1 without LD: scanning resumes from the held cnt.
- Mode switch 1→0: the next edge follows S immediately.
- Arithmetic: increment and compare use SEL_W+1 bits internally, so there is no aliasing when CHANNELS is a power of two.

## Timing
- Reset values: Y=0, CH=0, WRAP=0, ERR=0, cnt=0.
- Reset is asynchronous; it takes effect mid-cycle without waiting for an edge.
- On release, the first active edge in scan mode outputs channel 0.
- Latency: one cycle from D/S/E/MODE/LD sampled to Y/CH/ERR/WRAP.
- D is sampled at the same edge as sel; there is no separate data-capture stage.
- Scan period: CHANNELS cycles per full rotation. WRAP is high exactly 1 of every CHANNELS enabled cycles.
- LD and the counter reaching its end on the same edge: LD wins. sel = S, and cnt continues from S+1.
- E going HIGH for k cycles stretches the rotation by exactly k cycles.

## Configuration
- IC_MUX_SCAN_PARITY_EN defined:
  - Adds output P (out, 1), registered even parity, P = ^(next Y).
  - P has the same latency as Y, resets to 0, and is 0 whenever E=1.
- Not defined: port P is absent and there is no parity logic.

## Test plan
- Reset: with WIDTH=4, CHANNELS=4 and D=16'hDCBA, assert RST mid-cycle -> Y=0, CH=0, WRAP=0 and ERR=0 immediately, before any edge.
- Scan: MODE=1, E=0, D=16'hDCBA, 8 edges -> Y = A,B,C,D,A,B,C,D; CH = 0,1,2,3,0,1,2,3; WRAP high on the 4th and 8th.
- Load/priority: in scan mode, with Y currently showing channel 3, set LD=1 and S=1 -> next edge Y=B, CH=1, then C, D, A; no WRAP on the load edge.
- Enable freeze: in scan at CH=1, hold E=1 for 3 edges -> Y=0 and CH=1 throughout; after E=0, Y=C, CH=2.
- Non-power-of-two: CHANNELS=3, MODE=0, S=3 -> Y=0, ERR=1, CH=3. Then MODE=1, LD=1, S=3 -> ERR=1, and the following edges give CH=0,1,2 with WRAP at CH=2.
- Parity (IC_MUX_SCAN_PARITY_EN): WIDTH=4, channel value 4'b0111 selected -> P=1 on the same edge as Y; for 4'b0011, P=0.
